// File: rtl/cgra0_conf_writer_if.sv
// Configuration word source handshake: the source drives valid/data and the writer returns ready.
interface cgra0_conf_writer_if;
  localparam int unsigned DATA_W = 64;

  logic              conf_in_valid;
  logic [DATA_W-1:0] conf_in_data;
  logic              conf_in_ready;

  modport master (output conf_in_valid, output conf_in_data, input conf_in_ready);
  modport slave  (input conf_in_valid, input conf_in_data, output conf_in_ready);
endinterface

// File: rtl/cgra0_conf_writer.sv
// Streams a counted sequence of configuration words onto the PE broadcast bus, with optional
// inter-word gaps and a drain period before the completion pulse.
module cgra0_conf_writer #(
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               conf_qtd,
  cgra0_conf_writer_if.slave        conf_in,
  output logic [63:0]               conf_bus_out,
  output logic                      busy,
  output logic                      conf_done,
  output logic                      err_bad_type
);
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TYPE_W  = 8;
  localparam logic [TYPE_W-1:0] MAX_TYPE = TYPE_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A zero drain length bypasses DRAIN entirely.
  localparam state_t            DRAIN_ENTRY = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD  = (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD    = (GAP_CYCLES == 0)   ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   qtd_q, qtd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               bad_type;

  // Next state, counters and registered outputs.
  always_comb begin
    state_d  = state_q;
    qtd_d    = qtd_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    bus_d    = '0;
    err_d    = err_q;
    accept   = 1'b0;
    bad_type = conf_in.conf_in_data[TYPE_W-1:0] > MAX_TYPE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          qtd_d = conf_qtd;
          cnt_d = '0;
          err_d = 1'b0;
          if (conf_qtd == '0) begin
            state_d = DRAIN_ENTRY;
            tmr_d   = DRAIN_LOAD;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        accept = conf_in.conf_in_valid;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bad_type) err_d = 1'b1;
          else          bus_d = conf_in.conf_in_data;
          if (cnt_d == qtd_q) begin
            state_d = DRAIN_ENTRY;
            tmr_d   = DRAIN_LOAD;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            tmr_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = SEND;
        else             tmr_d   = tmr_q - CNT_W'(1);
      end
      DRAIN: begin
        if (tmr_q == '0) state_d = DONE;
        else             tmr_d   = tmr_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      qtd_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      bus_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qtd_q   <= qtd_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      bus_q   <= bus_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign conf_in.conf_in_ready = ready_q;
  assign conf_bus_out          = bus_q;
  assign busy                  = busy_q;
  assign conf_done             = done_q;
  assign err_bad_type          = err_q;
endmodule

// File: tb/tb_cgra0_conf_writer.sv
// Scoreboard bench: a timestamp model predicts every cycle's outputs; two DUTs (no gap, gap of 2)
// share the stimulus, one of them selected at a time.
module tb_cgra0_conf_writer;
  localparam int DRAIN = 3;
  localparam int GAP1  = 2;

  typedef struct {
    int          cyc;
    logic [63:0] bus;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, valid, sel, sel_next;
  logic [31:0] conf_qtd;
  logic [63:0] data;

  logic [63:0] bus0, bus1, bus;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic        rdy, busy_m, done_m, err_m;

  cgra0_conf_writer_if if0 ();
  cgra0_conf_writer_if if1 ();

  assign if0.conf_in_valid = valid && !sel;
  assign if0.conf_in_data  = data;
  assign if1.conf_in_valid = valid && sel;
  assign if1.conf_in_data  = data;

  cgra0_conf_writer #(.GAP_CYCLES(0), .DRAIN_CYCLES(DRAIN)) u_dut0 (
    .clk(clk), .rst(rst), .start(start && !sel), .conf_qtd(conf_qtd), .conf_in(if0),
    .conf_bus_out(bus0), .busy(busy0), .conf_done(done0), .err_bad_type(err0));

  cgra0_conf_writer #(.GAP_CYCLES(GAP1), .DRAIN_CYCLES(DRAIN)) u_dut1 (
    .clk(clk), .rst(rst), .start(start && sel), .conf_qtd(conf_qtd), .conf_in(if1),
    .conf_bus_out(bus1), .busy(busy1), .conf_done(done1), .err_bad_type(err1));

  assign bus    = sel ? bus1 : bus0;
  assign rdy    = sel ? if1.conf_in_ready : if0.conf_in_ready;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign err_m  = sel ? err1 : err0;

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   tb_timeout = 1'b0;
  exp_t exp_q[$];
  logic [63:0] src_q[$];

  // Model state: sequence activity and the cycles at which ready / done are due.
  bit m_active, m_err, m_rdy_now;
  int m_rem, m_rdy_at, m_done_at;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares all outputs.
  initial begin
    exp_t e;
    bit   to_seen = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("bus",   bus,             e.bus);
        chk("ready", 64'(rdy),        64'(e.rdy));
        chk("busy",  64'(busy_m),     64'(e.busy));
        chk("done",  64'(done_m),     64'(e.done));
        chk("err",   64'(err_m),      64'(e.err));
      end
      if (tb_timeout && !to_seen) begin
        to_seen = 1'b1;
        chk("timeout", 64'(tb_timeout), 64'd0);
      end
    end
  end

  // One clock of stimulus; predicts the outputs of the following cycle.
  task automatic step(input bit r, input bit st, input logic [31:0] q, input bit v,
                      input logic [63:0] d, output bit acc);
    exp_t e;
    int   k, g;
    bit   idle_k;
    @(negedge clk);
    sel = sel_next;
    rst = r; start = st; conf_qtd = q; valid = v; data = d;
    k   = cyc;
    g   = sel ? GAP1 : 0;
    acc = v && m_rdy_now;
    e.cyc = k + 1;
    e.bus = '0;
    if (r) begin
      m_active = 1'b0; m_rem = 0; m_err = 1'b0; m_done_at = -1;
    end else begin
      idle_k = !m_active;
      if (m_active && m_rem == 0 && k == m_done_at) m_active = 1'b0;
      if (st && idle_k) begin
        m_err = 1'b0; m_active = 1'b1; m_rem = int'(q);
        if (q == 0) m_done_at = k + DRAIN + 1;
        else        m_rdy_at  = k + 1;
      end
      if (acc) begin
        if (d[7:0] > 8'd7) m_err = 1'b1;
        else               e.bus = d;
        m_rem--;
        if (m_rem == 0) m_done_at = k + DRAIN + 1;
        else            m_rdy_at  = k + 1 + g;
      end
    end
    m_rdy_now = m_active && m_rem > 0 && (k + 1) >= m_rdy_at;
    e.rdy  = m_rdy_now;
    e.busy = m_active;
    e.done = m_active && m_rem == 0 && (k + 1) == m_done_at;
    e.err  = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 1'b0, {$urandom, $urandom}, acc);
  endtask

  task automatic fill(input int n, input int bad_pct);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      if (int'($urandom_range(99)) < bad_pct) w[7:0] = 8'(8 + $urandom_range(247));
      else                                    w[7:0] = 8'($urandom_range(7));
      src_q.push_back(w);
    end
  endtask

  task automatic run_seq(input int qtd, input int vprob, input int rst_after, input bit extra);
    bit          acc, v;
    int          n, guard;
    logic [63:0] w;
    n = 0; guard = 0;
    step(1'b0, 1'b1, 32'(qtd), 1'b0, '0, acc);
    while (m_active && guard < 3000) begin
      w = (src_q.size() > 0) ? src_q[0] : 64'h0;
      v = int'($urandom_range(99)) < vprob;
      step(1'b0, extra && ($urandom_range(3) == 0), $urandom, v, v ? w : {$urandom, $urandom}, acc);
      if (acc) begin
        void'(src_q.pop_front());
        n++;
        if (n == rst_after) begin
          w = (src_q.size() > 0) ? src_q[0] : 64'h0;
          step(1'b1, 1'b0, '0, 1'b1, w, acc);
          src_q.delete();
          break;
        end
      end
      guard++;
    end
    if (guard >= 3000) tb_timeout = 1'b1;
  endtask

  initial begin
    bit acc;
    int q;
    rst = 1'b1; start = 1'b0; conf_qtd = '0; valid = 1'b0; data = '0;
    sel = 1'b0; sel_next = 1'b0;
    m_active = 1'b0; m_err = 1'b0; m_rdy_now = 1'b0;
    m_rem = 0; m_rdy_at = 0; m_done_at = -1;

    step(1'b1, 1'b0, '0, 1'b0, '0, acc);
    step(1'b1, 1'b0, '0, 1'b0, '0, acc);
    idle(2);

    // Three back-to-back words on the no-gap writer.
    src_q.push_back(64'h0000_0000_0001_0001);
    src_q.push_back(64'h0000_0000_0002_0102);
    src_q.push_back(64'h0000_0000_0003_0203);
    run_seq(3, 100, 0, 1'b0);
    idle(3);

    // Empty sequence: drain then done only.
    run_seq(0, 100, 0, 1'b0);
    idle(2);

    // Second word has an illegal type; error stays set through the idle period.
    src_q.push_back(64'h1234_5678_0005_0A04);
    src_q.push_back(64'hDEAD_BEEF_0006_0B09);
    run_seq(2, 100, 0, 1'b0);
    idle(4);

    // Reset after the first of three words, then a normal single-word sequence.
    fill(3, 0);
    run_seq(3, 100, 1, 1'b0);
    idle(2);
    fill(1, 0);
    run_seq(1, 100, 0, 1'b0);
    idle(2);

    // Random valid with stray starts while busy.
    for (int s = 0; s < 6; s++) begin
      q = int'($urandom_range(1, 6));
      fill(q, 15);
      run_seq(q, 50, 0, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    // Switch to the gapped writer through a reset.
    sel_next = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0, '0, acc);
    idle(2);
    fill(2, 0);
    run_seq(2, 100, 0, 1'b0);
    idle(2);
    for (int s = 0; s < 6; s++) begin
      q = int'($urandom_range(0, 5));
      fill(q, 15);
      run_seq(q, 60, 0, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
